// File: rtl/pipe_skid_stage_pkg.sv
// Shared core stage constants and the occupancy state encoding used by
// pipe_skid_stage. RST_VAL for instruction payloads comes from here.
package pipe_skid_stage_pkg;

    localparam logic [31:0] INST_NOP      = 32'h0000_0013;
    localparam logic [31:0] ZeroWord      = 32'h0000_0000;
    localparam int          Hold_Flag_Bus = 3;

    // Encoding equals the entry count, so the state doubles as occ_o.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/pipe_entry_dff.sv
// One payload entry: enable flop with a synchronous clear-to-value that
// serves both reset and flush.
module pipe_entry_dff
    import pipe_skid_stage_pkg::*;
#(
    parameter int            DW      = 32,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, optional two-entry
// skid buffer (registered ready) and a flush that injects a bubble.
//
// Handshake: a payload moves on a side only in a cycle where both valid and
// ready are high; upstream keeps in_data_i stable while in_valid_i=1 and
// in_ready_o=0, and out_data_o is held while out_valid_o=1 and out_ready_i=0.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int            DW      = 32,
    parameter logic [DW-1:0] RST_VAL = {DW{1'b0}},
    parameter int            SKID    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [1:0]    occ_o
);

    occ_state_e    state_q;
    logic          m_v;
    logic          in_fire;
    logic          out_fire;
    logic [DW-1:0] m_q;

    assign m_v         = (state_q != OCC_EMPTY);
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = m_v & out_ready_i;
    assign out_valid_o = m_v;
    assign out_data_o  = m_v ? m_q : RST_VAL;
    assign occ_o       = state_q;

    generate
        if (SKID != 0) begin : g_skid
            occ_state_e    state_d;
            logic          rdy_q;
            logic          m_en;
            logic          s_en;
            logic [DW-1:0] m_d;
            logic [DW-1:0] s_q;

            always_comb begin
                state_d = state_q;
                m_en    = 1'b0;
                s_en    = 1'b0;
                m_d     = in_data_i;
                case (state_q)
                    OCC_EMPTY: begin
                        if (in_fire) begin
                            m_en    = 1'b1;
                            state_d = OCC_ONE;
                        end
                    end
                    OCC_ONE: begin
                        if (in_fire && out_fire) begin
                            m_en = 1'b1;
                        end else if (in_fire) begin
                            s_en    = 1'b1;
                            state_d = OCC_FULL;
                        end else if (out_fire) begin
                            state_d = OCC_EMPTY;
                        end
                    end
                    OCC_FULL: begin
                        // Ready is low here, so only the drain path exists.
                        if (out_fire) begin
                            m_en    = 1'b1;
                            m_d     = s_q;
                            state_d = OCC_ONE;
                        end
                    end
                    default: state_d = OCC_EMPTY;
                endcase
                if (flush_i) begin
                    state_d = OCC_EMPTY;
                end
            end

            // Ready is computed from the next state so it is a pure flop output.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= OCC_EMPTY;
                    rdy_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    rdy_q   <= (state_d != OCC_FULL);
                end
            end

            assign in_ready_o = rdy_q;

            pipe_entry_dff #(.DW(DW), .RST_VAL(RST_VAL)) u_main (
                .clk (clk),
                .rst (rst),
                .clr (flush_i),
                .en  (m_en),
                .d   (m_d),
                .q   (m_q)
            );

            pipe_entry_dff #(.DW(DW), .RST_VAL(RST_VAL)) u_skid (
                .clk (clk),
                .rst (rst),
                .clr (flush_i),
                .en  (s_en),
                .d   (in_data_i),
                .q   (s_q)
            );
        end else begin : g_noskid
            logic live_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= OCC_EMPTY;
                    live_q  <= 1'b0;
                end else begin
                    live_q <= 1'b1;
                    if (flush_i) begin
                        state_q <= OCC_EMPTY;
                    end else if (in_fire) begin
                        state_q <= OCC_ONE;
                    end else if (out_fire) begin
                        state_q <= OCC_EMPTY;
                    end
                end
            end

            // live_q keeps ready low through reset without a rst->ready path.
            assign in_ready_o = live_q & (out_ready_i | ~m_v);

            pipe_entry_dff #(.DW(DW), .RST_VAL(RST_VAL)) u_main (
                .clk (clk),
                .rst (rst),
                .clr (flush_i),
                .en  (in_fire),
                .d   (in_data_i),
                .q   (m_q)
            );
        end
    endgenerate

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed table and hand sequences for pipe_skid_stage in both modes,
// followed by a random scoreboard run.
module tb_pipe_skid_stage;
    import pipe_skid_stage_pkg::*;

    localparam logic [31:0] RV1 = INST_NOP;
    localparam logic [31:0] RV0 = 32'h0;
    localparam int          NRAND = 10000;

    logic        clk;
    logic        rst;
    logic        fl1, iv1, or1, fl0, iv0, or0;
    logic [31:0] d1, d0;
    logic        ir1, ov1, ir0, ov0;
    logic [31:0] od1, od0;
    logic [1:0]  occ1, occ0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q1[$];
    logic [31:0] exp_q0[$];

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
        logic        e_ir;
    } vec_t;

    vec_t vecs[$];

    pipe_skid_stage #(.DW(32), .RST_VAL(RV1), .SKID(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (fl1),
        .in_valid_i  (iv1),
        .in_ready_o  (ir1),
        .in_data_i   (d1),
        .out_valid_o (ov1),
        .out_ready_i (or1),
        .out_data_o  (od1),
        .occ_o       (occ1)
    );

    pipe_skid_stage #(.DW(32), .RST_VAL(RV0), .SKID(0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (fl0),
        .in_valid_i  (iv0),
        .in_ready_o  (ir0),
        .in_data_i   (d0),
        .out_valid_o (ov0),
        .out_ready_i (or0),
        .out_data_o  (od0),
        .occ_o       (occ0)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addv(input logic r, input logic f, input logic iv, input logic [31:0] d,
                        input logic o, input logic eov, input logic [31:0] eod,
                        input logic [1:0] eocc, input logic eir);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = o;
        v.e_ov = eov; v.e_od = eod; v.e_occ = eocc; v.e_ir = eir;
        vecs.push_back(v);
    endtask

    // SKID=0 driver: checks the combinational ready before the edge,
    // then the registered outputs after it.
    task automatic step0(input logic iv, input logic [31:0] d, input logic o, input logic f,
                         input logic e_ir, input logic e_ov, input logic [31:0] e_od,
                         input logic [1:0] e_occ);
        iv0 = iv; d0 = d; or0 = o; fl0 = f;
        #1;
        chk("s0 in_ready", {31'b0, ir0}, {31'b0, e_ir});
        @(posedge clk); #1;
        chk("s0 out_valid", {31'b0, ov0}, {31'b0, e_ov});
        chk("s0 out_data", od0, e_od);
        chk("s0 occ", {30'b0, occ0}, {30'b0, e_occ});
    endtask

    initial begin
        logic pend1, pend0, stall1, stall0;
        logic [31:0] hold1, hold0;
        logic fi1, fo1, fi0, fo0;

        rst = 1'b1;
        fl1 = 0; iv1 = 0; or1 = 0; d1 = '0;
        fl0 = 0; iv0 = 0; or0 = 0; d0 = '0;

        // reset with valid asserted
        for (int i = 0; i < 3; i++) addv(1, 0, 1, 32'hEE, 0, 0, RV1, 0, 0);
        addv(0, 0, 0, 32'h0, 0, 0, RV1, 0, 1);
        // streaming
        for (int i = 0; i < 8; i++) addv(0, 0, 1, 32'h11 + i, 1, 1, 32'h11 + i, 1, 1);
        addv(0, 0, 0, 32'h0, 1, 0, RV1, 0, 1);
        // stall into skid, then release
        addv(0, 0, 1, 32'hA0, 1, 1, 32'hA0, 1, 1);
        addv(0, 0, 1, 32'hA1, 0, 1, 32'hA0, 2, 0);
        addv(0, 0, 1, 32'hA2, 0, 1, 32'hA0, 2, 0);
        addv(0, 0, 1, 32'hA2, 1, 1, 32'hA1, 1, 1);
        addv(0, 0, 1, 32'hA2, 1, 1, 32'hA2, 1, 1);
        addv(0, 0, 0, 32'h0, 1, 0, RV1, 0, 1);
        // flush while full, with a payload offered
        addv(0, 0, 1, 32'hB0, 0, 1, 32'hB0, 1, 1);
        addv(0, 0, 1, 32'hB1, 0, 1, 32'hB0, 2, 0);
        addv(0, 1, 1, 32'hB2, 0, 0, RV1, 0, 1);
        addv(0, 0, 0, 32'h0, 0, 0, RV1, 0, 1);
        // flush with both in_fire and out_fire in the same cycle
        addv(0, 0, 1, 32'hC0, 0, 1, 32'hC0, 1, 1);
        addv(0, 1, 1, 32'hC1, 1, 0, RV1, 0, 1);
        addv(0, 0, 0, 32'h0, 1, 0, RV1, 0, 1);
        // reset mid-transfer
        addv(0, 0, 1, 32'hD0, 0, 1, 32'hD0, 1, 1);
        addv(1, 0, 1, 32'hD1, 1, 0, RV1, 0, 0);
        addv(0, 0, 0, 32'h0, 1, 0, RV1, 0, 1);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; fl1 = vecs[i].flush; iv1 = vecs[i].iv;
            d1 = vecs[i].d; or1 = vecs[i].ordy;
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), {31'b0, ov1}, {31'b0, vecs[i].e_ov});
            chk($sformatf("v%0d out_data", i), od1, vecs[i].e_od);
            chk($sformatf("v%0d occ", i), {30'b0, occ1}, {30'b0, vecs[i].e_occ});
            chk($sformatf("v%0d in_ready", i), {31'b0, ir1}, {31'b0, vecs[i].e_ir});
            if (vecs[i].rst) begin
                chk($sformatf("v%0d s0 rst ready", i), {31'b0, ir0}, 32'h0);
                chk($sformatf("v%0d s0 rst valid", i), {31'b0, ov0}, 32'h0);
            end
        end
        fl1 = 0; iv1 = 0; or1 = 0;

        // SKID=0 sequence: ready follows out_ready in the same cycle
        step0(1, 32'h21, 0, 0, 1, 1, 32'h21, 1);
        step0(1, 32'h22, 1, 0, 1, 1, 32'h22, 1);
        step0(1, 32'h23, 0, 0, 0, 1, 32'h22, 1);
        step0(1, 32'h23, 1, 0, 1, 1, 32'h23, 1);
        step0(0, 32'h0,  1, 0, 1, 0, RV0,    0);
        step0(1, 32'h24, 0, 0, 1, 1, 32'h24, 1);
        step0(1, 32'h25, 1, 1, 1, 0, RV0,    0);
        step0(0, 32'h0,  0, 0, 1, 0, RV0,    0);

        // random run, both modes side by side
        iv0 = 0; or0 = 0; fl0 = 0;
        pend1 = 0; pend0 = 0; stall1 = 0; stall0 = 0;
        hold1 = '0; hold0 = '0;
        for (int c = 0; c < NRAND; c++) begin
            if (!pend1) begin
                iv1 = (c < NRAND - 20) ? 1'($urandom_range(0, 1)) : 1'b0;
                d1  = $urandom;
            end
            if (!pend0) begin
                iv0 = (c < NRAND - 20) ? 1'($urandom_range(0, 1)) : 1'b0;
                d0  = $urandom;
            end
            or1 = (c < NRAND - 20) ? 1'($urandom_range(0, 1)) : 1'b1;
            or0 = (c < NRAND - 20) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            fi1 = iv1 & ir1; fo1 = ov1 & or1;
            fi0 = iv0 & ir0; fo0 = ov0 & or0;
            if (stall1) chk("r1 hold data", od1, hold1);
            if (stall0) chk("r0 hold data", od0, hold0);
            if (fo1) begin
                if (exp_q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r1 extra output: got %h expected none", od1);
                end else chk("r1 data", od1, exp_q1.pop_front());
            end
            if (fo0) begin
                if (exp_q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r0 extra output: got %h expected none", od0);
                end else chk("r0 data", od0, exp_q0.pop_front());
            end
            if (fi1) exp_q1.push_back(d1);
            if (fi0) exp_q0.push_back(d0);
            if (occ0 > 2'd1) chk("r0 occ max", {30'b0, occ0}, 32'd1);
            stall1 = ov1 & ~or1; hold1 = od1; pend1 = iv1 & ~ir1;
            stall0 = ov0 & ~or0; hold0 = od0; pend0 = iv0 & ~ir0;
            @(posedge clk); #1;
        end
        chk("r1 drained", exp_q1.size(), 32'd0);
        chk("r0 drained", exp_q0.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline-stage register with a valid/ready handshake, an optional two-entry skid buffer, and a flush that injects a bubble. It is the generic successor to the fixed hold-flag stage registers between the core's pipeline stages (if/id, id/ex, ex/mem). A stage instantiates one copy per bundled payload, for example all ID→EX fields concatenated. It gives true back-pressure without dropping or duplicating instructions, and keeps a registered ready so timing paths do not chain through the pipeline.

## Interface
Parameters:
- DW, 32: payload width in bits, ≥1.
- RST_VAL, {DW{1'b0}}: payload value presented on reset, on flush, and whenever out_valid_o=0 (bubble). Set to the `INST_NOP` field encoding for instruction payloads.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready_o. 0 = single register with combinational ready.

Ports:
- clk  in  1  clock. All state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high. Clears both entries.
- flush_i  in  1  discard all held entries and any entry accepted this cycle.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept. Reset value 1 after the first edge with rst=0; 0 while rst=1.
- in_data_i  in  DW  upstream payload.
- out_valid_o  out  1  downstream payload valid. Reset value 0.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DW  payload. Reset value RST_VAL.
- occ_o  out  2  number of valid entries held (0..2; max 1 when SKID=0). Reset value 0.

## Operation
- Transfers: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- SKID=1 state: main entry (m_v, m_d) drives the outputs; skid entry (s_v, s_d) holds the overflow.
  - in_ready_o = ~s_v, taken from a flop.
  - out_valid_o = m_v; out_data_o = m_v ? m_d : RST_VAL.
- SKID=1 state transitions, occ 0/1/2:
  - EMPTY (m_v=0): in_fire loads main → ONE.
  - ONE:
    - out_fire without in_fire → EMPTY.
    - out_fire with in_fire → main reloads with the new data, stays ONE.
    - in_fire without out_fire → data goes to skid → FULL, in_ready_o falls next cycle.
  - FULL: in_fire cannot occur. out_fire moves skid to main → ONE, in_ready_o rises next cycle.
- SKID=0:
  - in_ready_o = out_ready_i | ~m_v (combinational).
  - in_fire loads main; out_fire without in_fire clears it.
- Flush, both modes:
  - Next state is EMPTY with m_d = s_d = RST_VAL, regardless of in_valid_i or out_ready_i in the same cycle.
  - A payload with in_fire in the flush cycle is dropped.
  - out_fire in the flush cycle still counts as delivered.
- Priority: rst > flush_i > normal handshake.
- Ordering: payloads leave in acceptance order. None are duplicated or lost except through flush.
- Data registers load only on acceptance (and on flush or reset). Unused entries hold their value and add no toggle.

## Timing
- Latency: an entry accepted at edge N is visible on out_* after edge N, i.e. 1 cycle.
- Throughput: 1 payload per cycle while out_ready_i=1, in both modes.
- SKID=1: in_ready_o depends only on flops, with no in→out combinational path. One stall cycle is absorbed by the skid entry, and upstream sees ready=0 one cycle after the stall begins.
- SKID=0: combinational path out_ready_i → in_ready_o.
- Upstream must hold in_data_i stable while in_valid_i=1 and in_ready_o=0. The stage holds out_data_o stable while out_valid_o=1 and out_ready_i=0.
- Reset mid-transfer: the edge with rst=1 drops everything. After that edge: out_valid_o=0, occ_o=0, out_data_o=RST_VAL, in_ready_o=0 while rst remains high.

## Structure
- The shared core defines package holds the stage constants: `INST_NOP`, `ZeroWord`, `Hold_Flag_Bus`. RST_VAL is passed from there at instantiation.
- The entry register (enable + sync clear-to-value flop, width DW) is the natural sub-module: pipe_entry_dff. It is instantiated twice for SKID=1 and once for SKID=0, via a generate on SKID.
- The stage wrapper (e.g. an ID→EX bundle) concatenates fields into DW and splits them back out. No logic lives in the wrapper.

## Test plan
- Reset: hold rst=1 for 3 cycles with in_valid_i=1 → out_valid_o=0, out_data_o=RST_VAL, occ_o=0, in_ready_o=0. One cycle after rst falls, in_ready_o=1.
- Streaming, SKID=1: send 0x11..0x18 on consecutive cycles with out_ready_i=1 → the same 8 values appear in order, each 1 cycle after acceptance, occ_o=1 throughout.
- Stall: stream 0xA0,0xA1,0xA2 with out_ready_i=0 from the cycle 0xA0 appears → occ_o=2, in_ready_o=0, out_data_o stays 0xA0. Release out_ready_i → 0xA0, 0xA1, 0xA2 follow in order, nothing dropped or duplicated.
- Flush: with occ_o=2 holding 0xB0,0xB1, assert flush_i together with in_valid_i=1 carrying 0xB2 → next cycle occ_o=0, out_valid_o=0, out_data_o=RST_VAL (0x00000013 when RST_VAL=`INST_NOP`). 0xB2 is never output.
- SKID=0: with out_valid_o=1 and out_ready_i toggling 1,0,1 → in_ready_o follows out_ready_i in the same cycle, 1 payload per cycle, occ_o never exceeds 1.
- Randomised check: random in_valid_i and out_ready_i (50%) over 10k cycles in both modes → scoreboard sequence matches, with no change in out_data_o while out_valid_o & ~out_ready_i.
